// File: rtl/data_ram_pkg.sv
// Shared types and constants for data_ram: controller state encoding and depth derivation.
// The CLEAR state is used only when DATA_RAM_CLEAR_EN is defined.
package data_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  function automatic int unsigned depth_f(input int unsigned addr_w);
    return 32'd1 << addr_w;
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Word-addressed storage for data_ram: one synchronous write port and one registered read port.
// The read register clears on rst; the array contents are never touched by rst.
module data_ram_array
  import data_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  localparam int unsigned DEPTH = depth_f(ADDR_W);

  // Zero at time 0 so builds without the clear sweep still read back defined data.
  logic [DATA_W-1:0] r_mem [DEPTH] = '{default: '0};
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)       r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/data_ram.sv
// Single-port request/response RAM with optional zero-sweep controller.
// Define DATA_RAM_CLEAR_EN to build the CLEAR state, sweep pointer and clr handling.
module data_ram
  import data_ram_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  logic              w_accept;
  logic              w_rd;
  logic              w_we;
  logic [ADDR_W-1:0] w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic              r_rsp_valid;

  // rst wins over a request presented in the same cycle.
  assign w_accept = req_valid && req_ready && !rst;
  assign w_rd     = w_accept && !req_we;

`ifdef DATA_RAM_CLEAR_EN
  state_t            r_state;
  logic [ADDR_W-1:0] r_sweep_ptr;

  assign busy      = (r_state == CLEAR);
  assign req_ready = (r_state == IDLE) && !clr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= CLEAR;
      r_sweep_ptr <= '0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_rsp_valid <= w_rd;
      case (r_state)
        CLEAR: begin
          // Natural wrap returns the pointer to 0 as the sweep finishes.
          r_sweep_ptr <= r_sweep_ptr + ADDR_W'(1);
          if (&r_sweep_ptr) r_state <= IDLE;
        end
        IDLE: begin
          if (clr) begin
            r_state     <= CLEAR;
            r_sweep_ptr <= '0;
          end
        end
        default: r_state <= CLEAR;
      endcase
    end
  end

  assign w_we    = !rst && (busy || (w_accept && req_we));
  assign w_waddr = busy ? r_sweep_ptr : req_addr;
  assign w_wdata = busy ? '0 : req_wdata;
`else
  logic w_unused_clr;

  assign w_unused_clr = clr;
  assign busy         = 1'b0;
  assign req_ready    = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) r_rsp_valid <= 1'b0;
    else     r_rsp_valid <= w_rd;
  end

  assign w_we    = w_accept && req_we;
  assign w_waddr = req_addr;
  assign w_wdata = req_wdata;
`endif

  assign rsp_valid = r_rsp_valid;

  data_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (w_rd),
    .i_raddr (req_addr),
    .o_rdata (rsp_rdata)
  );

endmodule

// File: tb/tb_data_ram.sv
// Randomised scoreboard bench for data_ram against an array-level reference model.
// Follows DATA_RAM_CLEAR_EN so the same bench covers both builds.
module tb_data_ram;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 16;
`ifdef DATA_RAM_CLEAR_EN
  localparam bit CLEAR_EN = 1'b1;
`else
  localparam bit CLEAR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          req_ready;
  logic          rsp_valid;
  logic          busy;
  logic [DW-1:0] rsp_rdata;

  int            errors = 0;
  int            checks = 0;
  bit            armed = 1'b0;
  logic [DW-1:0] ref_mem [DEPTH];
  int            clear_left = 0;
  logic [DW-1:0] exp_q [$];
  logic [DW-1:0] last_rdata = '0;
  logic [DW-1:0] mon_exp;

  data_ram #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic zero_model();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
  endtask

  // One clock cycle of stimulus: drive, check handshake outputs mid-cycle, advance the model at the edge.
  task automatic cycle(input bit r, input bit c, input bit v, input bit we,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit exp_busy;
    bit exp_ready;
    bit acc;
    rst = r; clr = c; req_valid = v; req_we = we; req_addr = a; req_wdata = d;
    exp_busy  = CLEAR_EN && (clear_left > 0);
    exp_ready = CLEAR_EN ? (!exp_busy && !c) : 1'b1;
    @(negedge clk);
    if (armed) begin
      check("busy", {31'd0, busy}, {31'd0, exp_busy});
      check("req_ready", {31'd0, req_ready}, {31'd0, exp_ready});
    end
    @(posedge clk);
    acc = v && exp_ready && !r;
    if (r) begin
      if (CLEAR_EN) begin
        clear_left = DEPTH;
        zero_model();
      end
      last_rdata = '0;
      armed = 1'b1;
    end else begin
      if (acc && we) ref_mem[a] = d;
      else if (acc)  exp_q.push_back(ref_mem[a]);
      if (clear_left > 0) clear_left--;
      else if (CLEAR_EN && c) begin
        clear_left = DEPTH;
        zero_model();
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    cycle(1'b0, 1'b0, 1'b1, 1'b1, a, d);
  endtask

  task automatic rd(input logic [AW-1:0] a);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, a, '0);
  endtask

  // Monitor: every read accepted at an edge must answer in the very next cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (armed) begin
        check("rsp_valid", {31'd0, rsp_valid}, {31'd0, (exp_q.size() != 0)});
        if (exp_q.size() != 0) begin
          mon_exp = exp_q.pop_front();
          if (rsp_valid === 1'b1) begin
            check("rsp_rdata", {24'd0, rsp_rdata}, {24'd0, mon_exp});
            last_rdata = mon_exp;
          end
        end else if (rsp_valid !== 1'b1) begin
          check("rdata_hold", {24'd0, rsp_rdata}, {24'd0, last_rdata});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    zero_model();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(20);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle(2);

    wr(4'd3, 8'hA5);
    rd(4'd3);
    idle(2);

    wr(4'd0, 8'h11);
    wr(4'd1, 8'h22);
    wr(4'd2, 8'h33);
    rd(4'd0);
    rd(4'd1);
    rd(4'd2);
    idle(2);

    // clr with a concurrent read while idle
    cycle(1'b0, 1'b1, 1'b1, 1'b0, 4'd5, '0);
    idle(18);
    rd(4'd3);
    idle(2);

    // reset mid-sweep, then a clr attempt during the restarted sweep
    wr(4'd9, 8'h5A);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(7);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    idle(5);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(14);
    rd(4'd9);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, '0);
    idle(18);
    rd(4'd9);
    idle(2);

    for (int i = 0; i < 400; i++) begin
      bit r;
      bit c;
      bit v;
      r = ($urandom % 64) == 0;
      c = ($urandom % 24) == 0;
      v = !r && (($urandom % 4) != 0);
      cycle(r, c, v, 1'($urandom), AW'($urandom), DW'($urandom));
    end
    idle(20);
    for (int i = 0; i < DEPTH; i++) rd(AW'(i));
    idle(3);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/data_ram.md
DATA_RAM -- requirements
Module: data_ram

Interface
REQ-001 The block SHALL be configured by parameter DATA_W, default 8, giving the word width in bits (minimum 1).
REQ-002 The block SHALL be configured by parameter ADDR_W, default 4, giving the address width; DEPTH = 2**ADDR_W words.
REQ-003 The block SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 clr  input  1  one-cycle pulse requesting a full-array zero sweep.
REQ-007 req_valid  input  1  request present.
REQ-008 req_ready  output  1  request accepted when high with req_valid.
REQ-009 req_we  input  1  1 = write, 0 = read.
REQ-010 req_addr  input  ADDR_W  word address.
REQ-011 req_wdata  input  DATA_W  write data.
REQ-012 rsp_valid  output  1  read data valid, one-cycle pulse per accepted read.
REQ-013 rsp_rdata  output  DATA_W  read data, registered.
REQ-014 busy  output  1  clear sweep in progress.

Function
REQ-015 The controller SHALL have two states, CLEAR and IDLE.
REQ-016 CLEAR SHALL write 0 to address sweep_ptr each cycle, sweep_ptr counting 0 to DEPTH-1, then go to IDLE; a sweep takes exactly DEPTH cycles.
REQ-017 req_ready SHALL equal (state == IDLE) and not clr, combinationally.
REQ-018 busy SHALL be 1 exactly while in CLEAR.
REQ-019 An accepted write SHALL update mem[req_addr] at the accepting edge and SHALL produce no response.
REQ-020 An accepted read at edge N SHALL drive rsp_valid = 1 and rsp_rdata = mem[req_addr] in the cycle following edge N (latency 1); back-to-back reads SHALL each get a response, one per cycle.
REQ-021 rsp_rdata SHALL hold its last value while rsp_valid = 0.
REQ-022 A read of an address written in an earlier cycle SHALL return the new data; at most one request is accepted per cycle.
REQ-023 clr in IDLE SHALL enter CLEAR with sweep_ptr = 0 at the next edge; a concurrent req_valid SHALL NOT be accepted.
REQ-024 clr during CLEAR SHALL be ignored; the sweep SHALL NOT restart.
REQ-025 sweep_ptr SHALL wrap from DEPTH-1 to 0 on leaving CLEAR.

Reset
REQ-026 rst SHALL force state = CLEAR, sweep_ptr = 0, rsp_valid = 0, rsp_rdata = 0; busy = 1 and req_ready = 0 in the cycle after reset.
REQ-027 rst asserted mid-sweep or mid-read SHALL restart the sweep from 0 and drop any pending response.

Configuration
REQ-028 Macro DATA_RAM_CLEAR_EN SHALL compile in the CLEAR state, sweep_ptr and clr handling.
REQ-029 Without DATA_RAM_CLEAR_EN: state is always IDLE; clr is ignored; busy = 0; req_ready = 1 from the first cycle after reset; reset SHALL NOT modify array contents; array is zero at time 0 by initialisation only.

Structure
REQ-030 Package data_ram_pkg SHALL hold the state enum (CLEAR, IDLE) and the DEPTH-derivation constant function.
REQ-031 Storage SHALL be a sub-module data_ram_array (one write port, registered read port); the FSM, sweep counter and handshake SHALL stay in data_ram.

Verification
REQ-032 Reset, then wait: busy = 1 for 16 cycles (ADDR_W = 4), then req_ready = 1; reading all 16 addresses returns 0x00.
REQ-033 Write 0xA5 to addr 3, read addr 3 next cycle -> rsp_valid one cycle later, rsp_rdata = 0xA5.
REQ-034 Reads of addr 0,1,2 on consecutive cycles after writing 0x11,0x22,0x33 -> rsp_valid high three cycles, data 0x11,0x22,0x33 in order.
REQ-035 clr together with req_valid read in IDLE -> req_ready = 0, no response, busy = 1 for 16 cycles, then addr 3 reads 0x00.
REQ-036 rst pulsed at sweep cycle 7 -> busy remains high 16 further cycles; second clr during sweep does not extend it.
REQ-037 Build without DATA_RAM_CLEAR_EN: write 0x5A to addr 9, pulse rst and clr -> busy = 0, req_ready = 1, addr 9 still reads 0x5A.
